// File: rtl/seven_segment_pkg.sv
// Glyph geometry, sample points, digit codes and reader states shared by the seven-segment readers.
package seven_segment_pkg;

    localparam int SEG_T   = 20;
    localparam int DIG_W   = 80;
    localparam int DIG_H   = 140;
    localparam int NUM_SEG = 7;
    localparam int SEG_MID = SEG_T / 2;

    // Pattern bit order is [6:0] = a,b,c,d,e,f,g.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Sample points sit mid-stroke, indexed by pattern bit (0=g .. 6=a).
    localparam int UPPER_Y = 40;
    localparam int LOWER_Y = 100;
    localparam int SAMPLE_X [NUM_SEG] = '{DIG_W / 2, SEG_MID, SEG_MID, DIG_W / 2,
                                          DIG_W - SEG_MID, DIG_W - SEG_MID, DIG_W / 2};
    localparam int SAMPLE_Y [NUM_SEG] = '{DIG_H / 2, UPPER_Y, LOWER_Y, DIG_H - SEG_MID,
                                          LOWER_Y, UPPER_Y, SEG_MID};

    localparam logic [6:0] DIGIT_CODE [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        EVAL
    } state_t;

    // One-hot mask of the segment sampled at box offset (ox, oy), zero elsewhere.
    function automatic logic [NUM_SEG-1:0] sample_hit(input logic [9:0] ox, input logic [9:0] oy);
        logic [NUM_SEG-1:0] hit;
        for (int i = 0; i < NUM_SEG; i++) begin
            hit[i] = (ox == 10'(SAMPLE_X[i])) && (oy == 10'(SAMPLE_Y[i]));
        end
        return hit;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Maps a 7-bit segment pattern to a digit; purely combinational, no handshake.
// Unknown patterns (blank included) give digit 4'hF with err set.
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        digit = 4'hF;
        err   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pattern == DIGIT_CODE[i]) begin
                digit = 4'(i);
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a digit glyph from the pixel stream, debounces it over frames and publishes it.
// Result visible two cycles after the box's last pixel; an unconsumed result is overwritten and flagged in overrun.
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int CONFIRM  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       pix_on,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       overrun
);

    localparam logic [3:0] CONF = 4'(CONFIRM);

    state_t     state;
    logic [6:0] pattern;
    logic [6:0] prev_pattern;
    logic [3:0] count;

    // Offsets are 11-bit signed so positions left of or above the box stay negative.
    logic [10:0] dx, dy;
    logic [9:0]  ox, oy;
    logic        in_box, frame_start, last_pix;
    logic [6:0]  hit, pattern_upd, pattern_fresh;

    assign dx = {1'b0, sx} - 11'(ORIGIN_X);
    assign dy = {1'b0, sy} - 11'(ORIGIN_Y);
    assign ox = dx[9:0];
    assign oy = dy[9:0];

    assign in_box = pix_valid && !dx[10] && (ox < 10'(DIG_W))
                              && !dy[10] && (oy < 10'(DIG_H));
    assign frame_start = pix_valid && (sx == 10'd0) && (sy == 10'd0);
    assign last_pix    = in_box && (ox == 10'(DIG_W - 1)) && (oy == 10'(DIG_H - 1));

    assign hit           = in_box ? sample_hit(ox, oy) : 7'd0;
    assign pattern_upd   = (pattern & ~hit) | (hit & {7{pix_on}});
    assign pattern_fresh = hit & {7{pix_on}};

    logic       same;
    logic [3:0] count_next;
    logic       publish;

    // A changed pattern also publishes so CONFIRM=1 reports every change.
    always_comb begin
        same       = (pattern == prev_pattern);
        count_next = 4'd1;
        if (same) begin
            count_next = (count >= CONF) ? CONF : count + 4'd1;
        end
        publish = (state == EVAL) && (count_next == CONF) && ((count < CONF) || !same);
    end

    logic [3:0] dec_digit;
    logic       dec_err;

    seven_segment_decode u_decode (
        .pattern (pattern),
        .digit   (dec_digit),
        .err     (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pattern      <= 7'd0;
            prev_pattern <= 7'd0;
            count        <= 4'd0;
            out_valid    <= 1'b0;
            out_digit    <= 4'h0;
            out_err      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        pattern <= pattern_fresh;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (frame_start) begin
                        pattern <= pattern_fresh;
                    end else if (in_box) begin
                        pattern <= pattern_upd;
                        if (last_pix) begin
                            state <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    count <= count_next;
                    if (!same) begin
                        prev_pattern <= pattern;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (publish) begin
                out_valid <= 1'b1;
                out_digit <= dec_digit;
                out_err   <= dec_err;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed frames into two readers (origin 100,50 and origin 0,0 with pixel gaps); results checked by queue scoreboard.
module tb_seven_segment_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid, pix_on, sel;
    logic [9:0] sx, sy;
    logic       pv1, pv2;
    logic       ready1, ready2;
    logic       valid1, err1, ovr1;
    logic       valid2, err2, ovr2;
    logic [3:0] digit1, digit2;

    always #5 clk = ~clk;

    assign pv1 = pix_valid & ~sel;
    assign pv2 = pix_valid & sel;

    seven_segment_reader #(.ORIGIN_X(100), .ORIGIN_Y(50), .CONFIRM(2)) dut (
        .clk(clk), .rst(rst), .pix_valid(pv1), .sx(sx), .sy(sy), .pix_on(pix_on),
        .out_valid(valid1), .out_ready(ready1), .out_digit(digit1), .out_err(err1), .overrun(ovr1)
    );

    seven_segment_reader #(.ORIGIN_X(0), .ORIGIN_Y(0), .CONFIRM(2)) dut_org0 (
        .clk(clk), .rst(rst), .pix_valid(pv2), .sx(sx), .sy(sy), .pix_on(pix_on),
        .out_valid(valid2), .out_ready(ready2), .out_digit(digit2), .out_err(err2), .overrun(ovr2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] q1[$];
    logic [4:0] q2[$];

    // Segment a..g sample offsets and the box rows streamed per frame.
    int PX [7]   = '{40, 70, 70, 40, 10, 10, 40};
    int PY [7]   = '{10, 40, 100, 130, 100, 40, 70};
    int ROWS [6] = '{10, 40, 70, 100, 130, 139};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (valid1 === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out1: got {err,digit}=%0h, required no output (t=%0t)", {err1, digit1}, $time);
            end else begin
                check("out1", {27'd0, err1, digit1}, {27'd0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (valid2 === 1'b1 && ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out2: got {err,digit}=%0h, required no output (t=%0t)", {err2, digit2}, $time);
            end else begin
                check("out2", {27'd0, err2, digit2}, {27'd0, q2.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int y, input logic on, input bit gap);
        sx        = 10'(x);
        sy        = 10'(y);
        pix_on    = on;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        if (gap) begin
            sx     = 10'($urandom);
            sy     = 10'($urandom);
            pix_on = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // Streams frame start then the sampled box rows; n_rows/last_cols < full gives a truncated frame.
    task automatic frame(input logic [6:0] g, input int n_rows = 6, input int last_cols = 80);
        int   x0, y0, cols;
        bit   gaps;
        logic on;
        x0   = sel ? 0 : 100;
        y0   = sel ? 0 : 50;
        gaps = sel;
        idle(3);
        send(0, 0, 1'($urandom), gaps);
        for (int r = 0; r < n_rows; r++) begin
            cols = (r == n_rows - 1) ? last_cols : 80;
            for (int c = 0; c < cols; c++) begin
                on = 1'($urandom);
                for (int k = 0; k < 7; k++) begin
                    if (c == PX[k] && ROWS[r] == PY[k]) on = g[6-k];
                end
                send(x0 + c, y0 + ROWS[r], on, gaps);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
            idle(1);
            n++;
        end
        check("drain_pending", 32'(q1.size() + q2.size()), 32'd0);
        q1.delete();
        q2.delete();
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; sel = 1'b0; sx = '0; sy = '0; pix_on = 1'b0;
        ready1 = 1'b1; ready2 = 1'b1;
        idle(3);
        check("rst_valid", valid1, 0);
        check("rst_digit", digit1, 0);
        check("rst_err", err1, 0);
        check("rst_overrun", ovr1, 0);
        check("rst_valid2", valid2, 0);
        rst = 1'b0;

        // Digit 3: published after the second frame, exactly at T+2, never repeated.
        frame(7'h79);
        q1.push_back({1'b0, 4'd3});
        frame(7'h79);
        @(negedge clk);
        check("t1_valid", valid1, 0);
        @(negedge clk);
        check("t2_valid", valid1, 1);
        check("t2_digit", digit1, 3);
        check("t2_err", err1, 0);
        frame(7'h79);

        // 7,7,8,8
        frame(7'h70);
        q1.push_back({1'b0, 4'd7});
        frame(7'h70);
        frame(7'h7F);
        q1.push_back({1'b0, 4'd8});
        frame(7'h7F);
        drain();

        // Blank then segments a+d only
        frame(7'h00);
        q1.push_back({1'b1, 4'hF});
        frame(7'h00);
        frame(7'h48);
        q1.push_back({1'b1, 4'hF});
        frame(7'h48);
        drain();

        // Backpressure: 1 held until overwritten by 2
        ready1 = 1'b0;
        frame(7'h30);
        frame(7'h30);
        idle(3);
        check("bp_valid_1", valid1, 1);
        check("bp_digit_1", digit1, 1);
        check("bp_ovr_0", ovr1, 0);
        frame(7'h6D);
        idle(3);
        check("bp_hold_1", digit1, 1);
        frame(7'h6D);
        idle(3);
        check("bp_digit_2", digit1, 2);
        check("bp_valid_2", valid1, 1);
        check("bp_ovr_1", ovr1, 1);
        q1.push_back({1'b0, 4'd2});
        ready1 = 1'b1;
        idle(2);
        check("bp_valid_drop", valid1, 0);
        check("bp_ovr_sticky", ovr1, 1);
        drain();

        // Frame start injected at box row 70, then two full frames of 5
        ready1 = 1'b0;
        frame(7'h7F, 3, 40);
        frame(7'h5B);
        frame(7'h5B);
        idle(3);
        check("inj_valid", valid1, 1);
        check("inj_digit", digit1, 5);

        // Reset in the middle of a frame
        frame(7'h5B, 3, 40);
        rst = 1'b1;
        idle(1);
        check("mid_rst_valid", valid1, 0);
        check("mid_rst_digit", digit1, 0);
        check("mid_rst_err", err1, 0);
        check("mid_rst_overrun", ovr1, 0);
        rst = 1'b0;
        ready1 = 1'b1;
        frame(7'h5B);
        idle(4);
        check("post_rst_one_frame", valid1, 0);
        q1.push_back({1'b0, 4'd5});
        frame(7'h5B);
        drain();

        // Origin 0,0 with a gap after every pixel
        sel = 1'b1;
        frame(7'h7F);
        q2.push_back({1'b0, 4'd8});
        frame(7'h7F);
        drain();
        check("org0_overrun", ovr2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Recognises a seven-segment digit glyph drawn in a raster pixel stream. It is the read side of the on-screen digit renderer.
- Samples one point per segment inside a fixed 80x140 glyph box while the frame scans. At the end of the box it decodes the 7-bit pattern to a digit, debounces across frames and publishes the result on a valid/ready output.
- Sits beside the VGA pixel pipeline, tapping the same sx/sy/pixel stream as the display. Used for on-chip self-check of the displayed numbers.

Parameters:
- ORIGIN_X, 0, pixel x of the glyph box's top-left corner (0..560).
- ORIGIN_Y, 0, pixel y of the glyph box's top-left corner (0..340).
- CONFIRM, 2, number of consecutive frames with an identical pattern required before publishing (1..15).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  sx/sy/pix_on describe an active pixel this cycle
- sx  in  10  pixel x coordinate
- sy  in  10  pixel y coordinate
- pix_on  in  1  pixel is lit
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_digit  out  4  decoded digit 0..9, or 4'hF when out_err=1
- out_err  out  1  pattern is not a digit (includes blank)
- overrun  out  1  sticky: an unconsumed result was overwritten

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - out_valid=0, out_digit=4'h0, out_err=0, overrun=0.
  - state=IDLE, pattern=0, prev_pattern=0, count=0.
- Offsets: ox=sx-ORIGIN_X, oy=sy-ORIGIN_Y. The pixel is in the box when 0<=ox<80 and 0<=oy<140, using unsigned compares on sx/sy. Do not use wrapped subtraction.
- Sample points (ox,oy), with pattern bit order [6:0]=a,b,c,d,e,f,g:
  - a(40,10), b(70,40), c(70,100), d(40,130), e(10,100), f(10,40), g(40,70).
- Frame start is an accepted pixel with sx==0 and sy==0.
- IDLE: waits for frame start, then clears pattern and enters CAPTURE. The frame-start pixel itself is also sampled, so ORIGIN 0,0 works.
- CAPTURE:
  - On each accepted pixel at a sample point, the matching pattern bit <= pix_on.
  - On the accepted pixel at (ox,oy)=(79,139), call it cycle T, go to EVAL at T+1.
  - A frame start seen in CAPTURE clears pattern and stays in CAPTURE. The partial glyph is discarded.
  - pix_valid=0 cycles are ignored in every state.
- EVAL (exactly one cycle, then IDLE):
  - If pattern==prev_pattern: count=min(count+1,CONFIRM). Otherwise count=1 and prev_pattern=pattern.
  - Publish when the new count equals CONFIRM and the old count was below CONFIRM. Publishing happens once per stable change; a steady digit is not republished.
  - Published results are visible at T+2.
- Decode, combinational, on the pattern:
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - Any other value, including 00: out_err=1, out_digit=4'hF.
- Output handshake:
  - A transfer occurs when out_valid && out_ready. After a transfer out_valid drops next cycle unless there is a simultaneous publish.
  - Publish while out_valid=1 and out_ready=0: overwrite out_digit/out_err, keep out_valid=1, set overrun=1. overrun stays set until rst.
  - Publish together with a transfer: the old value is consumed, the new value is loaded, out_valid stays 1, and overrun does not change.
  - out_digit/out_err are stable while out_valid=1 and no publish occurs.
- Reset mid-CAPTURE: the partial pattern and debounce history are lost. The next result needs CONFIRM full frames.

Decomposition:
- Package seven_segment_pkg holds:
  - glyph geometry constants (SEG_T=20, DIG_W=80, DIG_H=140);
  - the seven sample-point offsets;
  - segment bit indices;
  - the ten 7-bit digit codes;
  - the state enum {IDLE, CAPTURE, EVAL}.
- One combinational sub-module, seven_segment_decode: 7-bit pattern in, 4-bit digit and err out. It is reused later by other readers.

Test Plan:
- Setup: CONFIRM=2, ORIGIN 100,50. Stream frames with digit 3 drawn (segments a,b,c,d,g lit), out_ready=1.
  - Frame 1 -> no output.
  - Frame 2 -> out_valid for 1 cycle at T+2 with out_digit=3, out_err=0.
  - Frame 3 -> no output.
- Frames alternate 7,7,8,8 -> outputs 7 then 8. Changing at frame 3 resets count to 1.
- Blank glyph for 2 frames -> out_err=1, out_digit=4'hF. Segments a+d only (pattern 48) -> out_err=1.
- out_ready=0, digits 1,1,2,2 -> out_digit holds 1 until the second publish, then 2 with overrun=1. Raising out_ready clears out_valid; overrun stays 1.
- Frame start injected at box row 70, then a full frame of 5, twice -> single output 5. rst asserted mid-CAPTURE -> all outputs 0 next cycle, and two further full frames are needed to publish.
- ORIGIN 0,0 with glyph 8, pix_valid deasserted on every other cycle -> output 8 after 2 frames. This checks gap tolerance and sampling of the frame-start pixel.
